// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: READ (03), JEDEC ID (9F) and STATUS (05) served from a 256x8 preloadable memory.
// Define SPI_RESP_FAST_READ_EN to add FAST READ (0B) with 8 dummy clocks; otherwise 0B is ignored.
//
// state  | meaning
// IDLE   | waiting for a synchronised cs fall
// CMD    | shifting in the 8-bit command
// ADDR   | shifting in 24 address bits (only [7:0] kept)
// DUMMY  | 8 dummy clocks before fast-read data
// DATA   | streaming memory bytes, address auto-increments
// ID     | streaming the three JEDEC ID bytes cyclically
// STAT   | streaming the status byte
// IGNORE | unsupported command, quiet until cs rises
module spi_flash_responder #(
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE, DUMMY} state_t;

  state_t     state;
  logic [7:0] mem [256];
  logic       cs_s1, cs_s2, cs_d, sck_s1, sck_s2, sck_d, mosi_s1, mosi_s2;
  logic [1:0] sync_cnt;
  logic [4:0] bit_cnt;
  logic [2:0] out_cnt;
  logic [6:0] cmd_sh;
  logic [7:0] addr, sh;
  logic [1:0] id_idx;
  logic       wcol;
`ifdef SPI_RESP_FAST_READ_EN
  logic       fast;
`endif

  // Edge detection waits until the synchronisers have refilled after reset,
  // so a cs already held low at release is not mistaken for a new fall.
  logic sync_ok, cs_fall, cs_rise, sck_rise, sck_fall;
  assign sync_ok  = (sync_cnt == 2'd3);
  assign cs_fall  = sync_ok & cs_d & ~cs_s2;
  assign cs_rise  = sync_ok & ~cs_d & cs_s2;
  assign sck_rise = ~cs_s2 & sck_s2 & ~sck_d;
  assign sck_fall = ~cs_s2 & ~sck_s2 & sck_d;

  logic [7:0] cmd_byte, addr_in, addr_nxt, stat_byte;
  assign cmd_byte  = {cmd_sh, mosi_s2};
  assign addr_in   = {addr[6:0], mosi_s2};
  assign addr_nxt  = addr + 8'd1;
  assign stat_byte = {STATUS_VAL[7:1], STATUS_VAL[0] | wcol};

  function automatic logic [7:0] id_byte(input logic [1:0] i);
    case (i)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      default: id_byte = JEDEC_ID[7:0];
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_s1    <= 1'b1;
      cs_s2    <= 1'b1;
      cs_d     <= 1'b1;
      sck_s1   <= 1'b0;
      sck_s2   <= 1'b0;
      sck_d    <= 1'b0;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
      sync_cnt <= 2'd0;
    end else begin
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      if (!sync_ok) sync_cnt <= sync_cnt + 2'd1;
    end
  end

  // No reset on the array; reads below see pre-write contents in a colliding cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      miso    <= 1'b0;
      miso_oe <= 1'b0;
      busy    <= 1'b0;
      bit_cnt <= 5'd0;
      out_cnt <= 3'd0;
      cmd_sh  <= 7'd0;
      addr    <= 8'd0;
      sh      <= 8'd0;
      id_idx  <= 2'd0;
      wcol    <= 1'b0;
`ifdef SPI_RESP_FAST_READ_EN
      fast    <= 1'b0;
`endif
    end else begin
      if (cs_rise) begin
        state   <= IDLE;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            state   <= CMD;
            bit_cnt <= 5'd0;
            busy    <= 1'b1;
`ifdef SPI_RESP_FAST_READ_EN
            fast    <= 1'b0;
`endif
          end
          CMD: if (sck_rise) begin
            cmd_sh  <= cmd_byte[6:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= 5'd0;
              out_cnt <= 3'd0;
              case (cmd_byte)
                8'h03: state <= ADDR;
                8'h9F: begin
                  state  <= ID;
                  sh     <= id_byte(2'd0);
                  id_idx <= 2'd1;
                end
                8'h05: begin
                  state <= STAT;
                  sh    <= stat_byte;
                  wcol  <= 1'b0;
                end
`ifdef SPI_RESP_FAST_READ_EN
                8'h0B: begin
                  state <= ADDR;
                  fast  <= 1'b1;
                end
`endif
                default: state <= IGNORE;
              endcase
            end
          end
          ADDR: if (sck_rise) begin
            addr    <= addr_in;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= 5'd0;
`ifdef SPI_RESP_FAST_READ_EN
              if (fast) begin
                state <= DUMMY;
              end else begin
                state <= DATA;
                sh    <= mem[addr_in];
              end
`else
              state <= DATA;
              sh    <= mem[addr_in];
`endif
            end
          end
          DUMMY: if (sck_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= 5'd0;
              state   <= DATA;
              sh      <= mem[addr];
            end
          end
          DATA, ID, STAT: if (sck_fall) begin
            miso    <= sh[7];
            miso_oe <= 1'b1;
            if (out_cnt == 3'd7) begin
              out_cnt <= 3'd0;
              if (state == DATA) begin
                addr <= addr_nxt;
                sh   <= mem[addr_nxt];
              end else if (state == ID) begin
                sh     <= id_byte(id_idx);
                id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
              end else begin
                sh   <= stat_byte;
                wcol <= 1'b0;
              end
            end else begin
              out_cnt <= out_cnt + 3'd1;
              sh      <= {sh[6:0], 1'b0};
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
      // A preload during a transfer wins over a same-cycle clear.
      if (wr_en && busy) wcol <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: an SPI master issues transfers and queues the expected bytes;
// a monitor pops and compares each byte the master receives.
module tb_spi_flash_responder;

  localparam time HALF = 80ns;

  logic       clk = 1'b0;
  logic       rst, sck, cs, mosi, wr_en;
  logic [7:0] wr_addr, wr_data;
  logic       miso, miso_oe, busy;

  spi_flash_responder dut (
    .clk(clk), .rst(rst), .sck(sck), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5ns clk = ~clk;

  typedef struct {
    string      nm;
    logic [7:0] data;
    bit         chk_data;
    bit         oe;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rx_byte;
  logic       rx_oe_all, rx_oe_any;
  logic       rx_stb = 1'b0;
  int         checks = 0;
  int         passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rx_stb) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk_data) chk(e.nm, {24'd0, rx_byte}, {24'd0, e.data});
        chk({e.nm, "_oe"}, {31'd0, e.oe ? rx_oe_all : rx_oe_any}, {31'd0, e.oe});
      end
    end
  end

  task automatic spi_bit(input logic b, output logic r, output logic o);
    mosi = b;
    #HALF;
    r = miso;
    o = miso_oe;
    sck = 1'b1;
    #HALF;
    sck = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, input bit cd, input logic [7:0] ed,
                      input bit eo, input string nm);
    exp_t       e;
    logic [7:0] r;
    logic       all1, any1, rb, ob;
    e.nm = nm; e.data = ed; e.chk_data = cd; e.oe = eo;
    exp_q.push_back(e);
    all1 = 1'b1;
    any1 = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], rb, ob);
      r[i] = rb;
      all1 &= ob;
      any1 |= ob;
    end
    rx_byte = r; rx_oe_all = all1; rx_oe_any = any1;
    #1 rx_stb = 1'b1;
    @(negedge clk);
    #1 rx_stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [7:0] a2, input logic [7:0] a1,
                          input logic [7:0] a0);
    xfer(c,  0, 8'h00, 0, "hdr_cmd");
    xfer(a2, 0, 8'h00, 0, "hdr_a2");
    xfer(a1, 0, 8'h00, 0, "hdr_a1");
    xfer(a0, 0, 8'h00, 0, "hdr_a0");
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rb, ob;
    rst = 1'b0; sck = 1'b0; cs = 1'b1; mosi = 1'b0;
    wr_en = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_oe",   {31'd0, miso_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    wr(8'h10, 8'hA5); wr(8'h11, 8'h3C); wr(8'hFF, 8'h11); wr(8'h00, 8'h22);

    // Basic read
    cs_low();
    chk("busy_active", {31'd0, busy}, 32'd1);
    send_hdr(8'h03, 8'h00, 8'h00, 8'h10);
    xfer(8'h00, 1, 8'hA5, 1, "rd_10");
    xfer(8'h00, 1, 8'h3C, 1, "rd_11");
    cs_high();
    chk("busy_idle", {31'd0, busy}, 32'd0);

    // sck toggling with cs high must be ignored
    for (int i = 0; i < 4; i++) begin
      sck = 1'b1; #HALF; sck = 1'b0; #HALF;
    end
    @(negedge clk);

    // Address wrap, upper address bytes discarded
    cs_low();
    send_hdr(8'h03, 8'h12, 8'h34, 8'hFF);
    xfer(8'h00, 1, 8'h11, 1, "rd_ff");
    xfer(8'h00, 1, 8'h22, 1, "rd_wrap00");
    cs_high();

    // JEDEC ID with cyclic repeat
    cs_low();
    xfer(8'h9F, 0, 8'h00, 0, "id_cmd");
    xfer(8'h00, 1, 8'hEF, 1, "id_0");
    xfer(8'h00, 1, 8'h40, 1, "id_1");
    xfer(8'h00, 1, 8'h16, 1, "id_2");
    xfer(8'h00, 1, 8'hEF, 1, "id_3");
    cs_high();

    // Write collision flag, then one-shot status
    cs_low();
    wr(8'h55, 8'h99);
    cs_high();
    cs_low();
    xfer(8'h05, 0, 8'h00, 0, "stat_cmd");
    xfer(8'h00, 1, 8'h01, 1, "stat_0");
    xfer(8'h00, 1, 8'h00, 1, "stat_1");
    cs_high();

    // Reset mid-data; no transfer restarts while cs stays low
    cs_low();
    send_hdr(8'h03, 8'h00, 8'h00, 8'h10);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, rb, ob);
    rst = 1'b0;
    #1;
    chk("midrst_oe",   {31'd0, miso_oe}, 32'd0);
    chk("midrst_miso", {31'd0, miso}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    xfer(8'h03, 0, 8'h00, 0, "postrst_0");
    xfer(8'h00, 0, 8'h00, 0, "postrst_1");
    chk("postrst_busy", {31'd0, busy}, 32'd0);
    cs_high();

    // Unsupported command stays quiet
    cs_low();
    xfer(8'hAB, 0, 8'h00, 0, "ign_cmd");
    xfer(8'h00, 0, 8'h00, 0, "ign_0");
    xfer(8'h00, 0, 8'h00, 0, "ign_1");
    cs_high();

    // Read still works (memory survived reset); abort mid-byte
    cs_low();
    send_hdr(8'h03, 8'h00, 8'h00, 8'h10);
    xfer(8'h00, 1, 8'hA5, 1, "rd_after_ign");
    for (int i = 0; i < 3; i++) spi_bit(1'b0, rb, ob);
    chk("abort_pre_oe", {31'd0, miso_oe}, 32'd1);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_miso", {31'd0, miso}, 32'd0);
    chk("abort_oe",   {31'd0, miso_oe}, 32'd0);
    repeat (4) @(negedge clk);

    // Fast read
    cs_low();
    send_hdr(8'h0B, 8'h00, 8'h00, 8'h10);
`ifdef SPI_RESP_FAST_READ_EN
    xfer(8'h00, 0, 8'h00, 0, "fr_dummy");
    xfer(8'h00, 1, 8'hA5, 1, "fr_data");
`else
    xfer(8'h00, 0, 8'h00, 0, "fr_off_0");
    xfer(8'h00, 0, 8'h00, 0, "fr_off_1");
`endif
    cs_high();

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter JEDEC_ID, default 24'hEF4016, returned by the 0x9F command MSB first.
REQ-002 SHALL have parameter STATUS_VAL, default 8'h00, returned by the 0x05 command.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port sck, input, 1: SPI serial clock from the master; asynchronous to clk.
REQ-006 SHALL have port cs, input, 1: chip select from the master, active-low.
REQ-007 SHALL have port mosi, input, 1: serial data, master to responder.
REQ-008 SHALL have port miso, output, 1: serial data, responder to master.
REQ-009 SHALL have port miso_oe, output, 1: high while miso carries a valid response bit.
REQ-010 SHALL have port wr_en, input, 1: preload strobe into internal 256x8 memory.
REQ-011 SHALL have port wr_addr, input, 8: preload address.
REQ-012 SHALL have port wr_data, input, 8: preload data.
REQ-013 SHALL have port busy, output, 1: high from cs fall to cs rise, as seen after synchronisation.

Function
REQ-014 SHALL pass sck, cs and mosi through two-flop synchronisers, then detect sck edges from the synchronised values; supported only for clk frequency >= 8x sck.
REQ-015 SHALL implement SPI mode 0: sample mosi on detected sck rise; update miso on detected sck fall; MSB first.
REQ-016 SHALL use FSM states IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE.
REQ-017 On synchronised cs fall, SHALL go IDLE->CMD with bit counter 0.
REQ-018 In CMD, after 8 bits, SHALL decode: 0x03->ADDR, 0x9F->ID, 0x05->STAT, any other->IGNORE.
REQ-019 In ADDR, SHALL shift 24 address bits and keep only bits [7:0]; after bit 24, SHALL go to DATA with mem[addr] loaded into the output shifter.
REQ-020 The first response bit SHALL appear on miso within 4 clk of the sck fall that follows the last command or address bit.
REQ-021 In DATA, after each 8 output bits, SHALL increment the address modulo 256 (0xFF wraps to 0x00) and load the next byte.
REQ-022 In ID, SHALL output the 3 JEDEC_ID bytes, then repeat them cyclically until cs rises.
REQ-023 In STAT, SHALL output STAT_BYTE repeatedly, where STAT_BYTE = STATUS_VAL with bit 0 ORed with a one-shot "write-collision" flag.
REQ-024 The write-collision flag SHALL set when wr_en is high while busy is high; it SHALL clear after being output once in STAT.
REQ-025 In IGNORE, SHALL hold miso_oe low and ignore mosi until cs rises.
REQ-026 On synchronised cs rise in any state, SHALL abort the transfer and return to IDLE on the next clk, with miso=0 and miso_oe=0.
REQ-027 wr_en SHALL write mem[wr_addr]<=wr_data in all states.
REQ-028 When wr_en addresses the byte currently being loaded into the shifter in the same clk, the shifter SHALL receive the old data.
REQ-029 sck edges while cs is high SHALL be ignored.

Reset
REQ-030 While rst is low: state=IDLE; miso=0; miso_oe=0; busy=0; counters, shifters and address=0; write-collision flag=0; synchronisers cleared to cs=1, sck=0, mosi=0.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 rst assertion mid-transfer SHALL take effect immediately; after release, the next transfer SHALL start only after a fresh cs fall.

Configuration
REQ-033 With macro SPI_RESP_FAST_READ_EN defined, command 0x0B SHALL behave as 0x03 but with 8 dummy sck cycles after the address (new state DUMMY), and data starting on the sck fall after the 8th dummy bit.
REQ-034 Without SPI_RESP_FAST_READ_EN, 0x0B SHALL go to IGNORE.

Verification
REQ-035 Preload mem[0x10]=0xA5, mem[0x11]=0x3C; cs low; send 03 00 00 10; clock 16 bits -> miso reads A5 3C; miso_oe high during data only.
REQ-036 Preload mem[0xFF]=0x11, mem[0x00]=0x22; send 03 12 34 FF; read 2 bytes -> 11 22 (address wraps, upper address bits ignored).
REQ-037 Send 9F; read 4 bytes -> EF 40 16 EF.
REQ-038 Pulse wr_en during a transfer; then in a new transfer send 05 and read 2 bytes -> 01 00 (flag one-shot).
REQ-039 Send 0xAB then 16 sck cycles -> miso_oe stays 0; the next 03 transfer still works; raising cs mid-byte during DATA -> miso=0 and miso_oe=0 within 4 clk.
REQ-040 With SPI_RESP_FAST_READ_EN defined, send 0B 00 00 10 plus 1 dummy byte -> A5 follows; without the macro, 0B -> miso_oe stays 0.
